fx2_fifo_arbiter: RTL

FX2_FIFO_ARBITER -- requirements
Module: fx2_fifo_arbiter

---
 rtl/fx2_fifo_arbiter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/fx2_fifo_arbiter.sv
// Arbitrates a video and an audio byte stream onto the FX2 slave FIFO bus.
// Units are written atomically; audio partial packets are committed after an idle timeout.
module fx2_fifo_arbiter #(
    parameter int VID_UNIT      = 2,
    parameter int AUD_UNIT      = 4,
    parameter int AUD_MAX_RUN   = 8,
    parameter int AUD_PKT_BYTES = 512,
    parameter int PKT_TIMEOUT   = 4095
) (
    input  logic       FX2_IFCLK,
    input  logic       MAX2_RESET,
    input  logic       enable,
    input  logic [7:0] vid_data,
    input  logic       vid_valid,
    output logic       vid_ready,
    input  logic [7:0] aud_data,
    input  logic       aud_valid,
    output logic       aud_ready,
    input  logic       FX2_FLAGA,
    input  logic       FX2_FLAGB,
    output logic [1:0] FX2_FIFOADDR,
    output logic       FX2_SLWR,
    output logic       FX2_PKTEND,
    output logic [7:0] fd_out
);

    localparam int UNIT_MAX = (VID_UNIT > AUD_UNIT) ? VID_UNIT : AUD_UNIT;
    localparam int CW = $clog2(UNIT_MAX + 1);
    localparam int RW = $clog2(AUD_MAX_RUN + 1);
    localparam int PW = (AUD_PKT_BYTES > 1) ? $clog2(AUD_PKT_BYTES) : 1;
    localparam int TW = $clog2(PKT_TIMEOUT + 1);

    localparam logic [CW-1:0] VID_LAST  = CW'(VID_UNIT - 1);
    localparam logic [CW-1:0] AUD_LAST  = CW'(AUD_UNIT - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(AUD_MAX_RUN);
    localparam logic [PW-1:0] PART_LAST = PW'(AUD_PKT_BYTES - 1);
    localparam logic [TW-1:0] IDLE_MAX  = TW'(PKT_TIMEOUT);

    localparam logic [1:0] EP_VID  = 2'b00;
    localparam logic [1:0] EP_AUD  = 2'b10;
    localparam logic [1:0] EP_PARK = 2'b01;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SWITCH = 3'd1;
    localparam logic [2:0] S_WR_VID = 3'd2;
    localparam logic [2:0] S_WR_AUD = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    r_target;
    logic [1:0]    r_fifoaddr;
    logic          r_slwr;
    logic          r_pktend;
    logic [7:0]    r_fd;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_aud_run;
    logic [PW-1:0] r_aud_part;
    logic [TW-1:0] r_aud_idle;

    logic          w_vid_xfer;
    logic          w_aud_xfer;
    logic          w_commit_pend;
    logic          w_starve;
    logic          w_grant;
    logic [2:0]    w_grant_st;
    logic [1:0]    w_grant_ep;
    logic          w_vid_grant;
    logic          w_aud_unit_done;
    logic [2:0]    w_state_nx;
    logic [2:0]    w_target_nx;
    logic [1:0]    w_addr_nx;
    logic [CW-1:0] w_cnt_nx;

    assign vid_ready    = (r_state == S_WR_VID) & FX2_FLAGA;
    assign aud_ready    = (r_state == S_WR_AUD) & FX2_FLAGB;
    assign w_vid_xfer   = vid_valid & vid_ready;
    assign w_aud_xfer   = aud_valid & aud_ready;
    assign FX2_FIFOADDR = r_fifoaddr;
    assign FX2_SLWR     = r_slwr;
    assign FX2_PKTEND   = r_pktend;
    assign fd_out       = r_fd;

    assign w_commit_pend   = (r_aud_idle == IDLE_MAX) && (r_aud_part != {PW{1'b0}});
    assign w_starve        = (r_aud_run == RUN_MAX) && vid_valid && FX2_FLAGA;
    assign w_aud_unit_done = w_aud_xfer && (r_cnt == AUD_LAST);
    assign w_vid_grant     = (r_state == S_IDLE) && w_grant && (w_grant_st == S_WR_VID);

    // Pending commit ignores enable so a stop still flushes the partial packet
    always_comb begin
        w_grant    = 1'b0;
        w_grant_st = S_IDLE;
        w_grant_ep = r_fifoaddr;
        if (w_commit_pend) begin
            w_grant    = 1'b1;
            w_grant_st = S_COMMIT;
            w_grant_ep = EP_AUD;
        end else if (enable && w_starve) begin
            w_grant    = 1'b1;
            w_grant_st = S_WR_VID;
            w_grant_ep = EP_VID;
        end else if (enable && aud_valid && FX2_FLAGB) begin
            w_grant    = 1'b1;
            w_grant_st = S_WR_AUD;
            w_grant_ep = EP_AUD;
        end else if (enable && vid_valid && FX2_FLAGA) begin
            w_grant    = 1'b1;
            w_grant_st = S_WR_VID;
            w_grant_ep = EP_VID;
        end else begin
            w_grant    = 1'b0;
        end
    end

    // Next-state logic; a unit holds its state until its last byte transfers
    always_comb begin
        w_state_nx  = r_state;
        w_target_nx = r_target;
        w_addr_nx   = r_fifoaddr;
        w_cnt_nx    = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_cnt_nx = {CW{1'b0}};
                    if (w_grant_ep != r_fifoaddr) begin
                        w_state_nx  = S_SWITCH;
                        w_target_nx = w_grant_st;
                        w_addr_nx   = w_grant_ep;
                    end else begin
                        w_state_nx  = w_grant_st;
                    end
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_SWITCH: w_state_nx = r_target;
            S_WR_VID: begin
                if (w_vid_xfer && (r_cnt == VID_LAST)) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = {CW{1'b0}};
                end else if (w_vid_xfer) begin
                    w_cnt_nx   = r_cnt + CW'(1);
                end else begin
                    w_state_nx = S_WR_VID;
                end
            end
            S_WR_AUD: begin
                if (w_aud_unit_done) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = {CW{1'b0}};
                end else if (w_aud_xfer) begin
                    w_cnt_nx   = r_cnt + CW'(1);
                end else begin
                    w_state_nx = S_WR_AUD;
                end
            end
            S_COMMIT: w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // Control state, unit byte count and endpoint select
    always_ff @(posedge FX2_IFCLK or posedge MAX2_RESET) begin
        if (MAX2_RESET) begin
            r_state    <= S_IDLE;
            r_target   <= S_IDLE;
            r_fifoaddr <= EP_PARK;
            r_cnt      <= {CW{1'b0}};
        end else begin
            r_state    <= w_state_nx;
            r_target   <= w_target_nx;
            r_fifoaddr <= w_addr_nx;
            r_cnt      <= w_cnt_nx;
        end
    end

    // Bus pipeline: the byte accepted on one edge is strobed out on the next cycle
    always_ff @(posedge FX2_IFCLK or posedge MAX2_RESET) begin
        if (MAX2_RESET) begin
            r_slwr   <= 1'b1;
            r_pktend <= 1'b1;
            r_fd     <= 8'h00;
        end else begin
            r_slwr   <= ~(w_vid_xfer | w_aud_xfer);
            r_pktend <= (w_state_nx != S_COMMIT);
            if (w_vid_xfer) begin
                r_fd <= vid_data;
            end else if (w_aud_xfer) begin
                r_fd <= aud_data;
            end else begin
                r_fd <= r_fd;
            end
        end
    end

    // Audio fairness run length, packet fill level and idle timer
    always_ff @(posedge FX2_IFCLK or posedge MAX2_RESET) begin
        if (MAX2_RESET) begin
            r_aud_run  <= {RW{1'b0}};
            r_aud_part <= {PW{1'b0}};
            r_aud_idle <= {TW{1'b0}};
        end else begin
            if (w_vid_grant) begin
                r_aud_run <= {RW{1'b0}};
            end else if (w_aud_unit_done && vid_valid && (r_aud_run != RUN_MAX)) begin
                r_aud_run <= r_aud_run + RW'(1);
            end else begin
                r_aud_run <= r_aud_run;
            end

            if (r_state == S_COMMIT) begin
                r_aud_part <= {PW{1'b0}};
            end else if (w_aud_xfer && (r_aud_part == PART_LAST)) begin
                r_aud_part <= {PW{1'b0}};
            end else if (w_aud_xfer) begin
                r_aud_part <= r_aud_part + PW'(1);
            end else begin
                r_aud_part <= r_aud_part;
            end

            if (w_aud_xfer || (r_state == S_COMMIT)) begin
                r_aud_idle <= {TW{1'b0}};
            end else if (r_aud_idle != IDLE_MAX) begin
                r_aud_idle <= r_aud_idle + TW'(1);
            end else begin
                r_aud_idle <= r_aud_idle;
            end
        end
    end

endmodule
